// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage bridge to 16-bit external SRAM, two half-word accesses per word
module sram_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int CW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t      state;
   logic [CW-1:0] cnt;
   logic [16:0] word_q;
   logic [31:0] data_q;
   logic        op_wr;
   logic [31:0] off;
   logic        active;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        unused_off;

   assign off        = address - 32'(BASE_ADDR);
   assign unused_off = &{1'b0, off[31:19], off[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         word_q    <= '0;
         data_q    <= '0;
         op_wr     <= 1'b0;
         read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en || rd_en) begin
                  word_q <= off[18:2];
                  data_q <= write_data;
                  op_wr  <= wr_en;
                  cnt    <= '0;
                  state  <= LOW;
               end
            end
            LOW: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= HIGH;
                  if (!op_wr)
                     read_data[15:0] <= SRAM_DQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= DONE;
                  if (!op_wr)
                     read_data[31:16] <= SRAM_DQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Bus pins decode straight from state so an async reset releases them at once
   assign active    = (state == LOW) || (state == HIGH);
   assign dq_oe     = active && op_wr;
   assign dq_out    = (state == HIGH) ? data_q[31:16] : data_q[15:0];
   assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
   assign SRAM_WE_N = !dq_oe;
   assign SRAM_ADDR = active ? {word_q, state == HIGH} : 18'd0;

   assign ready = (state == DONE) || ((state == IDLE) && !wr_en && !rd_en);

   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule
